// File: rtl/noc_stats_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : noc_stats_pkg                                                 |
// | Description : Shared types and constants for the NoC sink statistics        |
// |               stages: latency type, per-source statistics record, throttle  |
// |               LFSR taps and the packet-framing state encoding.              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package noc_stats_pkg;

  // Widths of the default monitor configuration (64-bit tdata, 32-bit stamp).
  localparam int unsigned LAT_WIDTH   = 32;
  localparam int unsigned STAT_CNT_W  = 32;
  localparam int unsigned STAT_SUM_W  = 48;

  typedef logic [LAT_WIDTH-1:0] latency_t;

  typedef struct packed {
    logic [STAT_CNT_W-1:0] count;
    logic [STAT_SUM_W-1:0] sum;
    latency_t              min;
    latency_t              max;
  } lat_stats_t;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam latency_t    LAT_MIN_INIT = '1;

  typedef enum logic [0:0] {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } frame_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_latency_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : axis_latency_monitor_if                                       |
// | Description : AXI-Stream bundle (tvalid/tready/tdata/tlast/tid/tdest).      |
// |               master drives the payload, slave drives tready.               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface axis_latency_monitor_if #(
  parameter int unsigned TDATA_WIDTH = 64,
  parameter int unsigned TDEST_WIDTH = 4,
  parameter int unsigned TID_WIDTH   = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input  tready);
  modport slave  (input  tvalid, tdata, tlast, tid, tdest, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_lfsr_throttle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_lfsr_throttle                                            |
// | Description : Pseudo-random tready generator. A 16-bit Galois LFSR advances |
// |               every cycle; tready is registered as lfsr >= stall_load, so   |
// |               stall_load=0 never stalls and 65535 almost always stalls.     |
// | Ports       : clk, rst_n (sync, active-low), stall_load_i[15:0], tready_o   |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module axis_lfsr_throttle
  import noc_stats_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] stall_load_i,
  output logic        tready_o
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        rst_n_q;
  logic        tready_q, tready_d;

  assign lfsr_d   = lfsr_step(lfsr_q);
  // rst_n_q holds tready low for the first cycle out of reset.
  assign tready_d = rst_n_q && (lfsr_q >= stall_load_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q   <= SEED;
      rst_n_q  <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      rst_n_q  <= 1'b1;
      tready_q <= tready_d;
    end
  end

  assign tready_o = tready_q;

endmodule
`default_nettype wire

// File: rtl/axis_latency_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_latency_monitor                                          |
// | Description : AXI-Stream sink with pseudo-random backpressure and per-source|
// |               packet latency statistics (count, sum, min, max). Latency is  |
// |               ticks minus the head-flit timestamp in tdata[TDATA_WIDTH/2-1:0]|
// | Ports       : clk, rst_n        - clock, sync active-low reset              |
// |               ticks             - shared free-running tick counter          |
// |               stall_load        - backpressure probability (65535 = max)    |
// |               measure_en        - statistics window, sampled on head flits  |
// |               axis_in           - AXI-Stream slave bundle                   |
// |               pkt_count/lat_sum/lat_min/lat_max - per-source statistics     |
// |               total_flits       - every accepted flit (wraps)               |
// |               error             - sticky bad tdest / out-of-range tid       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module axis_latency_monitor
  import noc_stats_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH = 64,
  parameter int unsigned TDEST_WIDTH = 4,
  parameter int unsigned TID_WIDTH   = 2,
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned TDEST       = 0,
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned SUM_WIDTH   = 48,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [TDATA_WIDTH/2-1:0]                    ticks,
  input  logic [15:0]                                 stall_load,
  input  logic                                        measure_en,
  axis_latency_monitor_if.slave                       axis_in,
  output logic [NUM_SOURCES-1:0][COUNT_WIDTH-1:0]     pkt_count,
  output logic [NUM_SOURCES-1:0][SUM_WIDTH-1:0]       lat_sum,
  output logic [NUM_SOURCES-1:0][TDATA_WIDTH/2-1:0]   lat_min,
  output logic [NUM_SOURCES-1:0][TDATA_WIDTH/2-1:0]   lat_max,
  output logic [COUNT_WIDTH-1:0]                      total_flits,
  output logic                                        error
);

  localparam int unsigned c_LAT_W = TDATA_WIDTH / 2;

  axis_lfsr_throttle #(.SEED(SEED)) u_throttle (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_load_i (stall_load),
    .tready_o     (axis_in.tready)
  );

  logic               w_accept;
  logic               w_head;
  logic               w_tid_ok;
  logic               w_bad;
  logic [c_LAT_W-1:0] w_lat;
  logic               w_unused;

  assign w_accept = axis_in.tvalid && axis_in.tready;
  assign w_tid_ok = 32'(axis_in.tid) < NUM_SOURCES;
  assign w_bad    = (axis_in.tdest != TDEST_WIDTH'(TDEST)) || !w_tid_ok;
  // Modular subtraction absorbs tick-counter wrap.
  assign w_lat    = ticks - axis_in.tdata[c_LAT_W-1:0];
  assign w_unused = ^axis_in.tdata[TDATA_WIDTH-1:c_LAT_W];

  // ---------------- packet framing ----------------
  frame_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_HEAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    w_head  = 1'b0;
    case (state_q)
      ST_HEAD: begin
        if (w_accept) begin
          w_head = 1'b1;
          if (!axis_in.tlast) state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        if (w_accept && axis_in.tlast) state_d = ST_HEAD;
      end
      default: state_d = ST_HEAD;
    endcase
  end

  // ---------------- stage 1: capture head sample ----------------
  logic                 s1_valid_q, s1_valid_d;
  logic [TID_WIDTH-1:0] s1_tid_q;
  logic [c_LAT_W-1:0]   s1_lat_q;

  assign s1_valid_d = w_head && measure_en && w_tid_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_tid_q   <= '0;
      s1_lat_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tid_q   <= axis_in.tid;
      s1_lat_q   <= w_lat;
    end
  end

  // ---------------- flit counter and sticky error ----------------
  logic [COUNT_WIDTH-1:0] total_flits_q;
  logic                   error_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_flits_q <= '0;
      error_q       <= 1'b0;
    end else if (w_accept) begin
      total_flits_q <= total_flits_q + COUNT_WIDTH'(1);
      if (w_bad) error_q <= 1'b1;
    end
  end

  assign total_flits = total_flits_q;
  assign error       = error_q;

  // ---------------- stage 2: per-source statistics ----------------
  // Each source owns its registers and reads its own previous value, so
  // consecutive heads from one tid update on consecutive cycles safely.
  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    logic [COUNT_WIDTH-1:0] count_q;
    logic [SUM_WIDTH-1:0]   sum_q;
    logic [c_LAT_W-1:0]     min_q;
    logic [c_LAT_W-1:0]     max_q;
    logic                   w_hit;
    logic [SUM_WIDTH:0]     w_sum_ext;

    assign w_hit     = s1_valid_q && (s1_tid_q == TID_WIDTH'(i));
    assign w_sum_ext = {1'b0, sum_q} + (SUM_WIDTH + 1)'(s1_lat_q);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        count_q <= '0;
        sum_q   <= '0;
        min_q   <= '1;
        max_q   <= '0;
      end else if (w_hit) begin
        if (count_q != '1) count_q <= count_q + COUNT_WIDTH'(1);
        sum_q <= w_sum_ext[SUM_WIDTH] ? '1 : w_sum_ext[SUM_WIDTH-1:0];
        if (s1_lat_q < min_q) min_q <= s1_lat_q;
        if (s1_lat_q > max_q) max_q <= s1_lat_q;
      end
    end

    assign pkt_count[i] = count_q;
    assign lat_sum[i]   = sum_q;
    assign lat_min[i]   = min_q;
    assign lat_max[i]   = max_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_latency_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axis_latency_monitor                                       |
// | Description : Self-checking bench: table of directed packets, hand-written  |
// |               timing/error/throttle sequences, and randomized packets       |
// |               scored against a packet-level statistics model.               |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_axis_latency_monitor;

  localparam int unsigned TDW  = 64;
  localparam int unsigned LW   = 32;
  localparam int unsigned DSTW = 4;
  localparam int unsigned TIDW = 2;
  localparam int unsigned NS   = 3;   // leaves tid=3 as an out-of-range source
  localparam int unsigned CW   = 32;
  localparam int unsigned SW   = 34;  // narrow enough to reach sum saturation

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n;
  logic [LW-1:0]           ticks;
  logic [15:0]             stall_load;
  logic                    measure_en;
  logic [NS-1:0][CW-1:0]   pkt_count;
  logic [NS-1:0][SW-1:0]   lat_sum;
  logic [NS-1:0][LW-1:0]   lat_min;
  logic [NS-1:0][LW-1:0]   lat_max;
  logic [CW-1:0]           total_flits;
  logic                    error;

  axis_latency_monitor_if #(.TDATA_WIDTH(TDW), .TDEST_WIDTH(DSTW), .TID_WIDTH(TIDW)) axis_in ();

  axis_latency_monitor #(
    .TDATA_WIDTH(TDW), .TDEST_WIDTH(DSTW), .TID_WIDTH(TIDW), .NUM_SOURCES(NS),
    .TDEST(0), .COUNT_WIDTH(CW), .SUM_WIDTH(SW), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ticks(ticks), .stall_load(stall_load),
    .measure_en(measure_en), .axis_in(axis_in), .pkt_count(pkt_count),
    .lat_sum(lat_sum), .lat_min(lat_min), .lat_max(lat_max),
    .total_flits(total_flits), .error(error)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- packet-level reference model ----------------
  longint m_cnt[NS], m_sum[NS], m_min[NS], m_max[NS];
  longint m_total;
  bit     m_err;

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      m_cnt[s] = 0; m_sum[s] = 0; m_min[s] = 64'hFFFF_FFFF; m_max[s] = 0;
    end
    m_total = 0; m_err = 0;
  endfunction

  function automatic void model_flit(input int tid, input int tdest);
    m_total = (m_total + 1) % (64'd1 << CW);
    if (tdest != 0 || tid >= NS) m_err = 1;
  endfunction

  function automatic void model_head(input int tid, input logic [31:0] lat);
    longint l;
    if (tid >= NS) return;
    l = longint'(lat);
    if (m_cnt[tid] < (64'd1 << CW) - 1) m_cnt[tid]++;
    m_sum[tid] = m_sum[tid] + l;
    if (m_sum[tid] > (64'd1 << SW) - 1) m_sum[tid] = (64'd1 << SW) - 1;
    if (l < m_min[tid]) m_min[tid] = l;
    if (l > m_max[tid]) m_max[tid] = l;
  endfunction

  // ---------------- drivers (always entered #1 after a clock edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input int tid, input int tdest, input logic [63:0] data,
                           input bit last, input bit meas, input logic [31:0] tk,
                           output bit ok);
    bit r;
    axis_in.tvalid = 1'b1;
    axis_in.tdata  = data;
    axis_in.tlast  = last;
    axis_in.tid    = TIDW'(tid);
    axis_in.tdest  = DSTW'(tdest);
    measure_en     = meas;
    ticks          = tk;
    ok = 0;
    for (int c = 0; c < 4000; c++) begin
      r = axis_in.tready;   // registered, stable for the whole cycle
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    axis_in.tvalid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL handshake_timeout: got tready=0 for 4000 cycles, expected acceptance");
    end
  endtask

  task automatic send_packet(input int tid, input int tdest, input int nfl,
                             input logic [31:0] ts, input logic [31:0] tk,
                             input bit mh, input bit mb);
    bit ok;
    for (int f = 0; f < nfl; f++) begin
      logic [63:0] d;
      d = (f == 0) ? {$urandom(), ts} : {$urandom(), $urandom()};
      send_flit(tid, tdest, d, f == nfl - 1, (f == 0) ? mh : mb, tk, ok);
      if (ok) begin
        model_flit(tid, tdest);
        if (f == 0 && mh) model_head(tid, tk - ts);
      end
    end
  endtask

  task automatic chk_src(input string tag, input int s, input longint c, input longint sm,
                         input longint mn, input longint mx);
    chk({tag, "_count"}, pkt_count[s], c);
    chk({tag, "_sum"},   lat_sum[s],   sm);
    chk({tag, "_min"},   lat_min[s],   mn);
    chk({tag, "_max"},   lat_max[s],   mx);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int s = 0; s < NS; s++) chk_src(tag, s, 0, 0, 64'hFFFF_FFFF, 0);
    chk({tag, "_total"},  total_flits, 0);
    chk({tag, "_error"},  error, 0);
    chk({tag, "_tready"}, axis_in.tready, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          tid;
    int          nfl;
    logic [31:0] ts;
    logic [31:0] tk;
    longint      e_cnt, e_sum, e_min, e_max, e_total;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  ok;
    int  rdy;

    // tid1 packets: 3 flits each, latencies 5, 50, 20.
    tbl[0] = '{1, 3, 32'd1000,       32'd1005, 1, 5,              5,    5,            4};
    tbl[1] = '{1, 3, 32'd2000,       32'd2050, 2, 55,             5,    50,           7};
    tbl[2] = '{1, 3, 32'd3000,       32'd3020, 3, 75,             5,    50,           10};
    // tid0: wrapped stamp, then max-latency packets driving the sum to saturation.
    tbl[3] = '{0, 1, 32'hFFFF_FFF0,  32'h10,   1, 64'h20,         64'h20, 64'h20,     11};
    tbl[4] = '{0, 1, 32'd1,          32'd0,    2, 64'h1_0000_001F, 64'h20, 64'hFFFF_FFFF, 12};
    tbl[5] = '{0, 1, 32'd1,          32'd0,    3, 64'h2_0000_001E, 64'h20, 64'hFFFF_FFFF, 13};
    tbl[6] = '{0, 1, 32'd1,          32'd0,    4, 64'h3_0000_001D, 64'h20, 64'hFFFF_FFFF, 14};
    tbl[7] = '{0, 1, 32'd1,          32'd0,    5, 64'h3_FFFF_FFFF, 64'h20, 64'hFFFF_FFFF, 15};
    tbl[8] = '{0, 1, 32'h100,        32'h120,  6, 64'h3_FFFF_FFFF, 64'h20, 64'hFFFF_FFFF, 16};

    axis_in.tvalid = 1'b0; axis_in.tdata = '0; axis_in.tlast = 1'b0;
    axis_in.tid = '0; axis_in.tdest = '0;
    ticks = '0; stall_load = 16'd0; measure_en = 1'b0; rst_n = 1'b0;
    model_reset();

    // ---- reset state, then tready with stall_load=0 ----
    idle(2);
    chk_reset_state("reset");
    rst_n = 1'b1;
    idle(1);
    chk("tready_first_cycle", axis_in.tready, 0);
    rdy = 0;
    for (int i = 0; i < 8; i++) begin idle(1); if (axis_in.tready) rdy++; end
    chk("tready_always_at_load0", rdy, 8);

    // ---- single-flit packet, statistics appear two cycles after acceptance ----
    send_flit(2, 0, {32'hDEAD_BEEF, 32'd100}, 1'b1, 1'b1, 32'd130, ok);
    chk("stats_not_early", pkt_count[2], 0);
    idle(1);
    chk_src("t1_src2", 2, 1, 30, 30, 30);

    // ---- table-driven packets ----
    for (int v = 0; v < 9; v++) begin
      send_packet(tbl[v].tid, 0, tbl[v].nfl, tbl[v].ts, tbl[v].tk, 1'b1, 1'b1);
      idle(3);
      chk_src($sformatf("tbl%0d", v), tbl[v].tid, tbl[v].e_cnt, tbl[v].e_sum,
              tbl[v].e_min, tbl[v].e_max);
      chk($sformatf("tbl%0d_total", v), total_flits, tbl[v].e_total);
    end

    // ---- measure_en dropped mid-packet; next head with measure_en=0 ignored ----
    send_packet(2, 0, 4, 32'd500, 32'd507, 1'b1, 1'b0);
    idle(3);
    chk_src("meas_mid", 2, 2, 37, 7, 30);
    send_packet(2, 0, 1, 32'd0, 32'd999, 1'b0, 1'b0);
    idle(3);
    chk_src("meas_off", 2, 2, 37, 7, 30);
    chk("meas_total", total_flits, 21);

    // ---- tdest mismatch on a body flit: sticky error, counting intact ----
    chk("error_clear", error, 0);
    send_flit(1, 0, {32'h0, 32'd10}, 1'b0, 1'b1, 32'd14, ok);
    chk("error_after_good_head", error, 0);
    send_flit(1, 1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 32'd14, ok);
    chk("error_next_cycle", error, 1);
    send_flit(1, 0, 64'h0, 1'b1, 1'b0, 32'd14, ok);
    idle(3);
    chk("error_sticky", error, 1);
    chk_src("err_src1", 1, 4, 79, 4, 50);
    chk("err_total", total_flits, 24);

    // ---- one-cycle reset returns every output to its reset value ----
    rst_n = 1'b0;
    idle(1);
    chk_reset_state("midrst");
    rst_n = 1'b1;

    // ---- throttle: stall_load=32768, tvalid held for 65535 cycles ----
    // Every nonzero LFSR value appears once per period except the seed
    // (0xACE1 >= 0x8000), which is masked by the first-cycle hold-off.
    stall_load     = 16'd32768;
    axis_in.tvalid = 1'b1; axis_in.tlast = 1'b1; axis_in.tid = '0;
    axis_in.tdest  = '0;   measure_en = 1'b0;
    n = 0;
    for (int i = 0; i < 65535; i++) begin
      idle(1);
      if (axis_in.tready) n++;
    end
    idle(1);
    axis_in.tvalid = 1'b0;
    idle(2);
    chk("throttle_ready_count", n, 32767);
    chk("throttle_no_lost_flits", total_flits, 64'(n));
    chk("throttle_uncounted", pkt_count[0], 0);

    // ---- out-of-range tid: accepted, flagged, not counted ----
    stall_load = 16'd0;
    chk("badtid_error_before", error, 0);
    send_flit(3, 0, {32'h0, 32'd1}, 1'b1, 1'b1, 32'd9, ok);
    chk("badtid_error", error, 1);
    idle(3);
    chk("badtid_total", total_flits, 64'(n) + 1);
    for (int s = 0; s < NS; s++) chk($sformatf("badtid_cnt%0d", s), pkt_count[s], 0);

    // ---- randomized packets against the model ----
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    model_reset();
    for (int p = 0; p < 60; p++) begin
      int          tid, tdest, nfl;
      logic [31:0] tk, lat;
      stall_load = 16'($urandom_range(0, 45000));
      tid   = ($urandom_range(0, 29) == 0) ? 3 : int'($urandom_range(0, NS - 1));
      tdest = ($urandom_range(0, 29) == 0) ? 1 : 0;
      nfl   = int'($urandom_range(1, 4));
      tk    = $urandom();
      lat   = (p % 7 == 0) ? $urandom() : 32'($urandom_range(0, 5000));
      send_packet(tid, tdest, nfl, tk - lat, tk, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    for (int s = 0; s < NS; s++)
      chk_src($sformatf("rand_src%0d", s), s, m_cnt[s], m_sum[s], m_min[s], m_max[s]);
    chk("rand_total", total_flits, m_total);
    chk("rand_error", error, m_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
